// File: rtl/clock_setter.sv
// clock_setter: MM:SS clock with two-button time setting.
// Ports:
//   CLOCK_50      - single clock, all logic on its rising edge
//   RESET         - synchronous active-high reset, highest priority
//   keyMode       - async active-low push-button, cycles RUN -> SET_MIN -> SET_SEC -> RUN
//   keyInc        - async active-low push-button, increments minutes/seconds while setting
//   minDecs/minOnes/secDecs/secOnes - registered BCD digits MM:SS
//   blankMask     - registered per-digit blank request {minDecs, minOnes, secDecs, secOnes}
//   secondsPoint  - registered 1 Hz point, toggles every half second
//   mode          - registered state: RUN=00, SET_MIN=01, SET_SEC=10
module clock_setter #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       keyMode,
  input  logic       keyInc,
  output logic [3:0] minDecs,
  output logic [3:0] minOnes,
  output logic [3:0] secDecs,
  output logic [3:0] secOnes,
  output logic [3:0] blankMask,
  output logic       secondsPoint,
  output logic [1:0] mode
);

  localparam int unsigned HalfCount    = CLK_HZ / 2;
  localparam int unsigned PsW          = (HalfCount > 1) ? $clog2(HalfCount) : 1;
  localparam logic [PsW-1:0] PsLast    = PsW'(HalfCount - 1);
  localparam int unsigned DbW          = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0] DbLast    = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StSetMin = 2'b01,
    StSetSec = 2'b10
  } state_e;

  // Increment a base-60 BCD pair, wrapping 59 -> 00.
  function automatic logic [7:0] bcd60_inc(input logic [3:0] tens, input logic [3:0] ones);
    if (ones >= 4'd9) begin
      if (tens >= 4'd5) return 8'h00;
      return {tens + 4'd1, 4'd0};
    end
    return {tens, ones + 4'd1};
  endfunction

  // Key index 0 = mode, 1 = inc.
  logic [1:0]     meta_q, sync_q, stable_q;
  logic [DbW-1:0] db_cnt_q [2];
  logic [1:0]     key_press;

  // A press is the cycle in which a stable-high key is about to be accepted as low.
  always_comb begin
    key_press = 2'b00;
    for (int i = 0; i < 2; i++) begin
      key_press[i] = stable_q[i] && !sync_q[i] && (db_cnt_q[i] == DbLast);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      meta_q   <= 2'b11;
      sync_q   <= 2'b11;
      stable_q <= 2'b11;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      meta_q <= {keyInc, keyMode};
      sync_q <= meta_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbLast) begin
          stable_q[i] <= sync_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  state_e         state_q, state_d;
  logic [PsW-1:0] presc_q;
  logic           point_q, point_d;
  logic [3:0]     blank_q, blank_d;
  logic [3:0]     min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
  logic           mode_press, inc_press, half_tick, sec_tick, run_restart;
  logic [7:0]     sec_inc, min_inc;

  always_comb begin
    mode_press  = key_press[0];
    // A simultaneous mode press wins; the inc press is dropped.
    inc_press   = key_press[1] && !key_press[0];
    half_tick   = (presc_q == PsLast);
    sec_tick    = half_tick && point_q;
    sec_inc     = bcd60_inc(sec_tens_q, sec_ones_q);
    min_inc     = bcd60_inc(min_tens_q, min_ones_q);
    run_restart = mode_press && (state_q == StSetSec);

    state_d = state_q;
    if (mode_press) begin
      unique case (state_q)
        StRun:    state_d = StSetMin;
        StSetMin: state_d = StSetSec;
        default:  state_d = StRun;
      endcase
    end

    // Re-entering RUN restarts the seconds phase so the first second is full length.
    point_d = point_q;
    if (run_restart)    point_d = 1'b0;
    else if (half_tick) point_d = !point_q;

    // Blank mask is derived from next-state values so it stays aligned with mode/point.
    blank_d = 4'b0000;
    unique case (state_d)
      StSetMin: blank_d = point_d ? 4'b1100 : 4'b0000;
      StSetSec: blank_d = point_d ? 4'b0011 : 4'b0000;
      default:  blank_d = 4'b0000;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q    <= StRun;
      presc_q    <= '0;
      point_q    <= 1'b0;
      blank_q    <= 4'b0000;
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
    end else begin
      state_q <= state_d;
      point_q <= point_d;
      blank_q <= blank_d;
      if (run_restart || half_tick) presc_q <= '0;
      else                          presc_q <= presc_q + PsW'(1);

      case (state_q)
        StRun: begin
          if (sec_tick) begin
            {sec_tens_q, sec_ones_q} <= sec_inc;
            // Seconds wrapped from 59, so carry into the minutes.
            if (sec_inc == 8'h00) {min_tens_q, min_ones_q} <= min_inc;
          end
        end
        StSetMin: if (inc_press) {min_tens_q, min_ones_q} <= min_inc;
        StSetSec: if (inc_press) {sec_tens_q, sec_ones_q} <= sec_inc;
        default: ;
      endcase
    end
  end

  assign minDecs      = min_tens_q;
  assign minOnes      = min_ones_q;
  assign secDecs      = sec_tens_q;
  assign secOnes      = sec_ones_q;
  assign blankMask    = blank_q;
  assign secondsPoint = point_q;
  assign mode         = state_q;

endmodule

// File: tb/tb_clock_setter.sv
// tb_clock_setter: directed self-checking bench for clock_setter
// (CLK_HZ = 20, DEBOUNCE_CYCLES = 4). A key driven low at a falling edge is
// accepted at the 6th following rising edge (2 sync + 4 debounce).
module tb_clock_setter;

  logic       clk;
  logic       RESET;
  logic       keyMode;
  logic       keyInc;
  logic [3:0] minDecs, minOnes, secDecs, secOnes;
  logic [3:0] blankMask;
  logic       secondsPoint;
  logic [1:0] mode;
  logic [15:0] tv;

  int errors = 0;
  int checks = 0;

  assign tv = {minDecs, minOnes, secDecs, secOnes};

  clock_setter #(
    .CLK_HZ          (20),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .CLOCK_50     (clk),
    .RESET        (RESET),
    .keyMode      (keyMode),
    .keyInc       (keyInc),
    .minDecs      (minDecs),
    .minOnes      (minOnes),
    .secDecs      (secDecs),
    .secOnes      (secOnes),
    .blankMask    (blankMask),
    .secondsPoint (secondsPoint),
    .mode         (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    RESET   = 1'b1;
    keyMode = 1'b1;
    keyInc  = 1'b1;
    step(2);
    RESET   = 1'b0;
  endtask

  task automatic press_mode(input int n);
    for (int k = 0; k < n; k++) begin
      keyMode = 1'b0;
      step(8);
      keyMode = 1'b1;
      step(8);
    end
  endtask

  task automatic press_inc(input int n);
    for (int k = 0; k < n; k++) begin
      keyInc = 1'b0;
      step(8);
      keyInc = 1'b1;
      step(8);
    end
  endtask

  task automatic test_reset();
    RESET   = 1'b1;
    keyMode = 1'b1;
    keyInc  = 1'b1;
    step(3);
    checks++;
    if (tv !== 16'h0000) begin errors++; $display("FAIL reset_time: got %h expected 0000", tv); end
    checks++;
    if (mode !== 2'b00) begin errors++; $display("FAIL reset_mode: got %b expected 00", mode); end
    checks++;
    if (blankMask !== 4'b0000) begin
      errors++; $display("FAIL reset_blank: got %b expected 0000", blankMask);
    end
    checks++;
    if (secondsPoint !== 1'b0) begin
      errors++; $display("FAIL reset_point: got %b expected 0", secondsPoint);
    end
  endtask

  task automatic test_run_minute();
    logic prev;
    int   toggles;
    do_reset();
    prev    = secondsPoint;
    toggles = 0;
    for (int i = 1; i <= 1200; i++) begin
      @(negedge clk);
      if (secondsPoint !== prev) toggles++;
      prev = secondsPoint;
      if (i == 9) begin
        checks++;
        if (secondsPoint !== 1'b0) begin
          errors++; $display("FAIL run_point_c9: got %b expected 0", secondsPoint);
        end
      end
      if (i == 10) begin
        checks++;
        if (secondsPoint !== 1'b1) begin
          errors++; $display("FAIL run_point_c10: got %b expected 1", secondsPoint);
        end
      end
      if (i == 19) begin
        checks++;
        if (tv !== 16'h0000) begin errors++; $display("FAIL run_c19: got %h expected 0000", tv); end
      end
      if (i == 20) begin
        checks++;
        if (tv !== 16'h0001) begin errors++; $display("FAIL run_c20: got %h expected 0001", tv); end
      end
    end
    checks++;
    if (tv !== 16'h0100) begin errors++; $display("FAIL run_minute: got %h expected 0100", tv); end
    checks++;
    if (toggles != 120) begin
      errors++; $display("FAIL run_toggles: got %0d expected 120", toggles);
    end
  endtask

  task automatic test_mode_blank();
    do_reset();
    keyMode = 1'b0;
    step(6);   // edge 6: SET_MIN, point 0
    checks++;
    if (mode !== 2'b01) begin errors++; $display("FAIL mb_mode1: got %b expected 01", mode); end
    checks++;
    if (blankMask !== 4'b0000) begin
      errors++; $display("FAIL mb_blank_c6: got %b expected 0000", blankMask);
    end
    step(2);
    keyMode = 1'b1;
    step(2);   // edge 10: point 1
    checks++;
    if (blankMask !== 4'b1100) begin
      errors++; $display("FAIL mb_blank_c10: got %b expected 1100", blankMask);
    end
    step(10);  // edge 20: point 0
    checks++;
    if (blankMask !== 4'b0000) begin
      errors++; $display("FAIL mb_blank_c20: got %b expected 0000", blankMask);
    end
    keyMode = 1'b0;
    step(6);   // edge 26: SET_SEC
    checks++;
    if (mode !== 2'b10) begin errors++; $display("FAIL mb_mode2: got %b expected 10", mode); end
    step(2);
    keyMode = 1'b1;
    step(2);   // edge 30: point 1
    checks++;
    if (blankMask !== 4'b0011) begin
      errors++; $display("FAIL mb_blank_c30: got %b expected 0011", blankMask);
    end
    step(10);  // edge 40: point 0
    checks++;
    if (blankMask !== 4'b0000) begin
      errors++; $display("FAIL mb_blank_c40: got %b expected 0000", blankMask);
    end
    keyMode = 1'b0;
    step(6);   // edge 46: RUN, prescaler and point cleared
    checks++;
    if (mode !== 2'b00) begin errors++; $display("FAIL mb_mode3: got %b expected 00", mode); end
    step(2);
    keyMode = 1'b1;
    step(2);   // edge 50: uncleared prescaler would toggle here
    checks++;
    if (secondsPoint !== 1'b0) begin
      errors++; $display("FAIL mb_point_c50: got %b expected 0", secondsPoint);
    end
    step(6);   // edge 56: first half tick after restart
    checks++;
    if (secondsPoint !== 1'b1) begin
      errors++; $display("FAIL mb_point_c56: got %b expected 1", secondsPoint);
    end
    checks++;
    if (blankMask !== 4'b0000) begin
      errors++; $display("FAIL mb_blank_run: got %b expected 0000", blankMask);
    end
    checks++;
    if (tv !== 16'h0000) begin errors++; $display("FAIL mb_time: got %h expected 0000", tv); end
  endtask

  task automatic test_set_min();
    do_reset();
    press_mode(1);
    keyInc = 1'b0;
    step(3);
    keyInc = 1'b1;
    step(10);
    checks++;
    if (tv !== 16'h0000) begin errors++; $display("FAIL sm_glitch: got %h expected 0000", tv); end
    keyInc = 1'b0;
    step(10);
    keyInc = 1'b1;
    step(10);
    checks++;
    if (tv !== 16'h0100) begin errors++; $display("FAIL sm_single: got %h expected 0100", tv); end
    press_inc(58);
    checks++;
    if (tv !== 16'h5900) begin errors++; $display("FAIL sm_59: got %h expected 5900", tv); end
    press_inc(1);
    checks++;
    if (tv !== 16'h0000) begin errors++; $display("FAIL sm_wrap: got %h expected 0000", tv); end
    checks++;
    if (mode !== 2'b01) begin errors++; $display("FAIL sm_mode: got %b expected 01", mode); end
  endtask

  task automatic test_set_5959();
    do_reset();
    press_mode(1);
    press_inc(59);
    checks++;
    if (tv !== 16'h5900) begin errors++; $display("FAIL s59_min: got %h expected 5900", tv); end
    press_mode(1);
    checks++;
    if (mode !== 2'b10) begin errors++; $display("FAIL s59_mode: got %b expected 10", mode); end
    press_inc(59);
    checks++;
    if (tv !== 16'h5959) begin errors++; $display("FAIL s59_sec: got %h expected 5959", tv); end
    press_inc(1);
    checks++;
    if (tv !== 16'h5900) begin errors++; $display("FAIL s59_nocarry: got %h expected 5900", tv); end
    press_inc(59);
    keyMode = 1'b0;
    step(6);   // back to RUN at this edge
    checks++;
    if (mode !== 2'b00) begin errors++; $display("FAIL s59_run: got %b expected 00", mode); end
    checks++;
    if (secondsPoint !== 1'b0) begin
      errors++; $display("FAIL s59_point: got %b expected 0", secondsPoint);
    end
    step(2);
    keyMode = 1'b1;
    step(17);  // 19 cycles into RUN
    checks++;
    if (tv !== 16'h5959) begin errors++; $display("FAIL s59_c19: got %h expected 5959", tv); end
    step(1);   // 20 cycles: secTick
    checks++;
    if (tv !== 16'h0000) begin errors++; $display("FAIL s59_c20: got %h expected 0000", tv); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    press_mode(1);
    press_inc(1);
    keyMode = 1'b0;
    keyInc  = 1'b0;
    step(8);
    keyMode = 1'b1;
    keyInc  = 1'b1;
    step(8);
    checks++;
    if (mode !== 2'b10) begin errors++; $display("FAIL sim_mode: got %b expected 10", mode); end
    checks++;
    if (tv !== 16'h0100) begin errors++; $display("FAIL sim_time: got %h expected 0100", tv); end
    press_inc(1);
    checks++;
    if (tv !== 16'h0101) begin errors++; $display("FAIL sim_after: got %h expected 0101", tv); end
  endtask

  task automatic test_reset_mid_set();
    do_reset();
    press_mode(1);
    press_inc(12);
    press_mode(1);
    press_inc(34);
    checks++;
    if (tv !== 16'h1234) begin errors++; $display("FAIL rm_pre: got %h expected 1234", tv); end
    keyInc = 1'b0;
    step(3);   // mid-debounce
    RESET = 1'b1;
    step(1);
    checks++;
    if (tv !== 16'h0000) begin errors++; $display("FAIL rm_time: got %h expected 0000", tv); end
    checks++;
    if (mode !== 2'b00) begin errors++; $display("FAIL rm_mode: got %b expected 00", mode); end
    checks++;
    if (blankMask !== 4'b0000) begin
      errors++; $display("FAIL rm_blank: got %b expected 0000", blankMask);
    end
    checks++;
    if (secondsPoint !== 1'b0) begin
      errors++; $display("FAIL rm_point: got %b expected 0", secondsPoint);
    end
    RESET  = 1'b0;
    keyInc = 1'b1;
    step(10);
    checks++;
    if (tv !== 16'h0000) begin errors++; $display("FAIL rm_after: got %h expected 0000", tv); end
  endtask

  initial begin
    RESET   = 1'b1;
    keyMode = 1'b1;
    keyInc  = 1'b1;
    test_reset();
    test_run_minute();
    test_mode_blank();
    test_set_min();
    test_set_5959();
    test_simultaneous();
    test_reset_mid_set();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
